fb_write_arbiter: RTL and testbench
===================================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter FB_SIZE, default 307200, number of framebuffer words (640x480).
REQ-002 SHALL have parameter CLEAR_DATA, default 8'h00, word written during a clear sweep.
REQ-003 SHALL have port CLOCK_50  in  1  the only clock; every flop is rising-edge on it.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port clear_req  in  1  request for a full-framebuffer clear sweep (level-sampled).
REQ-006 SHALL have port clear_busy  out  1  high while a clear sweep is in progress.
REQ-007 SHALL have ports p1_valid  in  1, p1_addr  in  19, p1_data  in  8: player-1 write request.
REQ-008 SHALL have port p1_ready  out  1  player-1 request accepted this cycle.
REQ-009 SHALL have ports p2_valid  in  1, p2_addr  in  19, p2_data  in  8: player-2 write request.
REQ-010 SHALL have port p2_ready  out  1  player-2 request accepted this cycle.
REQ-011 SHALL have ports wraddress  out  19, data  out  8, wren  out  1: registered RAM write port.
REQ-012 SHALL have port grant  out  2  registered source of the current write: 00 none, 01 p1, 10 p2, 11 clear.
REQ-013 SHALL have port addr_err  out  1  sticky flag for a dropped out-of-range request.

Function
REQ-014 SHALL implement two states: RUN (arbitrate players) and CLEAR (sweep).
REQ-015 A transfer SHALL occur on an edge where pX_valid and pX_ready are both 1.
REQ-016 pX_ready SHALL be combinational; it SHALL be 0 in CLEAR and 0 in a RUN cycle where clear_req=1.
REQ-017 In RUN, a single valid requester SHALL get ready=1 in the same cycle.
REQ-018 In RUN with both valid, the requester not granted most recently SHALL win; the other SHALL get ready=0.
REQ-019 The round-robin pointer SHALL update only on an accepted transfer.
REQ-020 An accepted in-range request SHALL appear one edge later as wren=1, wraddress=pX_addr, data=pX_data, grant=01/10.
REQ-021 An accepted request with addr >= FB_SIZE SHALL be consumed with wren=0 and grant=00, and SHALL set addr_err.
REQ-022 In RUN cycles without a transfer, wren SHALL be 0 and grant SHALL be 00; wraddress and data SHALL hold.
REQ-023 In RUN, clear_req=1 SHALL move to CLEAR on the edge where it is sampled and load the sweep counter with 0.
REQ-024 clear_req SHALL take priority over simultaneous player requests; no player is accepted in that cycle.
REQ-025 On each CLEAR edge: wraddress<=counter, data<=CLEAR_DATA, wren<=1, grant<=11, counter<=counter+1.
REQ-026 When counter=FB_SIZE-1, that edge SHALL return the state to RUN; wren=1 SHALL last exactly FB_SIZE cycles per sweep.
REQ-027 clear_req asserted during CLEAR SHALL be ignored; the sweep SHALL neither restart nor extend.
REQ-028 clear_busy SHALL equal (state==CLEAR).
REQ-029 A clear sweep SHALL clear addr_err on entry.
REQ-030 The counter SHALL be 19 bits, SHALL never exceed FB_SIZE-1, and SHALL not wrap.

Reset
REQ-031 While reset=1: wren=0, wraddress=0, data=0, grant=00, addr_err=0, p1_ready=p2_ready=0, and round-robin favours p1.
REQ-032 While reset=1, state SHALL be CLEAR with counter=0, so clear_busy=1.
REQ-033 After reset deasserts, a full clear sweep SHALL run automatically before any player is accepted.
REQ-034 reset asserted mid-sweep or mid-transfer SHALL abort it; a new sweep SHALL start from address 0 after release.

Verification (FB_SIZE=16 for simulation)
REQ-035 Release reset, hold valids low -> wren=1 for 16 consecutive cycles, addresses 0..15, data=00, grant=11, then clear_busy=0 and wren=0.
REQ-036 After the sweep, p1_valid=1, addr=5, data=01 for one cycle -> p1_ready=1; next edge wren=1, wraddress=5, data=01, grant=01.
REQ-037 Both valid for 4 cycles with p1 favoured -> grants alternate p1, p2, p1, p2; each wren matches the winner's addr/data.
REQ-038 clear_req=1 together with p2_valid=1 -> p2_ready=0, clear_busy=1 next cycle, and 16 clear writes follow; p2 is accepted after the sweep.
REQ-039 p1 addr=16 accepted -> wren stays 0 and addr_err=1; a subsequent clear_req -> addr_err=0.
REQ-040 reset pulsed at sweep address 7 -> outputs go to reset values, and after release the sweep restarts at address 0.

Source files
------------

// File: rtl/fb_write_arbiter_if.sv
// Framebuffer write-arbiter bundle: clear control, two player write requests,
// and the registered RAM write port.
interface fb_write_arbiter_if;
  logic        clear_req;
  logic        clear_busy;
  logic        p1_valid;
  logic [18:0] p1_addr;
  logic [7:0]  p1_data;
  logic        p1_ready;
  logic        p2_valid;
  logic [18:0] p2_addr;
  logic [7:0]  p2_data;
  logic        p2_ready;
  logic [18:0] wraddress;
  logic [7:0]  data;
  logic        wren;
  logic [1:0]  grant;
  logic        addr_err;

  modport master (
    output clear_req, p1_valid, p1_addr, p1_data, p2_valid, p2_addr, p2_data,
    input  clear_busy, p1_ready, p2_ready, wraddress, data, wren, grant, addr_err
  );

  modport slave (
    input  clear_req, p1_valid, p1_addr, p1_data, p2_valid, p2_addr, p2_data,
    output clear_busy, p1_ready, p2_ready, wraddress, data, wren, grant, addr_err
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: round-robin between two players, with a full
// clear sweep on request and automatically after reset.
module fb_write_arbiter #(
  parameter int unsigned FB_SIZE    = 307200,
  parameter logic [7:0]  CLEAR_DATA = 8'h00
) (
  input logic CLOCK_50,
  input logic reset,
  fb_write_arbiter_if.slave bus
);

  localparam logic [0:0]  ST_RUN   = 1'b0;
  localparam logic [0:0]  ST_CLEAR = 1'b1;
  localparam logic [19:0] FB_LIMIT = 20'(FB_SIZE);
  localparam logic [18:0] LAST_IDX = 19'(FB_SIZE - 1);

  logic [0:0]  state;
  logic [18:0] counter;
  logic        favour_p2;
  logic        run_ok;
  logic        p1_take;
  logic        p2_take;

  always_comb begin
    run_ok  = 1'b0;
    p1_take = 1'b0;
    p2_take = 1'b0;
    run_ok  = !reset && (state == ST_RUN) && !bus.clear_req;
    p1_take = run_ok && bus.p1_valid && (!bus.p2_valid || !favour_p2);
    p2_take = run_ok && bus.p2_valid && (!bus.p1_valid ||  favour_p2);
  end

  assign bus.p1_ready   = p1_take;
  assign bus.p2_ready   = p2_take;
  assign bus.clear_busy = (state == ST_CLEAR);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= ST_CLEAR;
      counter       <= '0;
      favour_p2     <= 1'b0;
      bus.wren      <= 1'b0;
      bus.wraddress <= '0;
      bus.data      <= '0;
      bus.grant     <= 2'b00;
      bus.addr_err  <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          bus.wraddress <= counter;
          bus.data      <= CLEAR_DATA;
          bus.wren      <= 1'b1;
          bus.grant     <= 2'b11;
          bus.addr_err  <= 1'b0;
          // Counter parks on the last index so it never exceeds FB_SIZE-1.
          if (counter == LAST_IDX) begin
            state <= ST_RUN;
          end else begin
            counter <= counter + 19'd1;
          end
        end
        default: begin
          if (bus.clear_req) begin
            state        <= ST_CLEAR;
            counter      <= '0;
            bus.wren     <= 1'b0;
            bus.grant    <= 2'b00;
            bus.addr_err <= 1'b0;
          end else if (p1_take) begin
            favour_p2 <= 1'b1;
            if ({1'b0, bus.p1_addr} < FB_LIMIT) begin
              bus.wren      <= 1'b1;
              bus.wraddress <= bus.p1_addr;
              bus.data      <= bus.p1_data;
              bus.grant     <= 2'b01;
            end else begin
              bus.wren     <= 1'b0;
              bus.grant    <= 2'b00;
              bus.addr_err <= 1'b1;
            end
          end else if (p2_take) begin
            favour_p2 <= 1'b0;
            if ({1'b0, bus.p2_addr} < FB_LIMIT) begin
              bus.wren      <= 1'b1;
              bus.wraddress <= bus.p2_addr;
              bus.data      <= bus.p2_data;
              bus.grant     <= 2'b10;
            end else begin
              bus.wren     <= 1'b0;
              bus.grant    <= 2'b00;
              bus.addr_err <= 1'b1;
            end
          end else begin
            bus.wren  <= 1'b0;
            bus.grant <= 2'b00;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a 16-word framebuffer.
module tb_fb_write_arbiter;

  logic CLOCK_50;
  logic reset;
  int unsigned checks;
  int unsigned errors;

  fb_write_arbiter_if bus ();

  fb_write_arbiter #(
    .FB_SIZE   (16),
    .CLEAR_DATA(8'h00)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk_write(input string tag, input logic en, input logic [18:0] addr,
                           input logic [7:0] d, input logic [1:0] g);
    chk({tag, ".wren"}, 32'(bus.wren), 32'(en));
    chk({tag, ".addr"}, 32'(bus.wraddress), 32'(addr));
    chk({tag, ".data"}, 32'(bus.data), 32'(d));
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
  endtask

  logic [1:0]  both_grant [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [18:0] both_p1a   [4] = '{19'd10, 19'd11, 19'd12, 19'd13};
  logic [7:0]  both_p1d   [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
  logic [18:0] both_p2a   [4] = '{19'd15, 19'd14, 19'd1, 19'd2};
  logic [7:0]  both_p2d   [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.clear_req = 1'b0;
    bus.p1_valid = 1'b1;
    bus.p1_addr = 19'd4;
    bus.p1_data = 8'h55;
    bus.p2_valid = 1'b0;
    bus.p2_addr = '0;
    bus.p2_data = '0;

    // Reset values, with p1 requesting to show it is not accepted.
    tick();
    tick();
    chk_write("rst", 1'b0, 19'd0, 8'h00, 2'b00);
    chk("rst.addr_err", 32'(bus.addr_err), 32'd0);
    chk("rst.busy", 32'(bus.clear_busy), 32'd1);
    chk("rst.p1_ready", 32'(bus.p1_ready), 32'd0);
    chk("rst.p2_ready", 32'(bus.p2_ready), 32'd0);
    bus.p1_valid = 1'b0;

    // Automatic sweep after reset.
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_write($sformatf("sweep%0d", i), 1'b1, 19'(i), 8'h00, 2'b11);
    end
    chk("sweep.busy_done", 32'(bus.clear_busy), 32'd0);
    tick();
    chk("sweep.idle_wren", 32'(bus.wren), 32'd0);
    chk("sweep.idle_grant", 32'(bus.grant), 32'd0);

    // Single p1 write.
    bus.p1_valid = 1'b1;
    bus.p1_addr = 19'd5;
    bus.p1_data = 8'h01;
    #1;
    chk("p1.ready", 32'(bus.p1_ready), 32'd1);
    tick();
    bus.p1_valid = 1'b0;
    chk_write("p1", 1'b1, 19'd5, 8'h01, 2'b01);
    tick();
    chk_write("p1.hold", 1'b0, 19'd5, 8'h01, 2'b00);

    // Single p2 write; leaves p1 favoured.
    bus.p2_valid = 1'b1;
    bus.p2_addr = 19'd9;
    bus.p2_data = 8'h22;
    #1;
    chk("p2.ready", 32'(bus.p2_ready), 32'd1);
    tick();
    bus.p2_valid = 1'b0;
    chk_write("p2", 1'b1, 19'd9, 8'h22, 2'b10);

    // Both valid: alternation p1, p2, p1, p2.
    for (int i = 0; i < 4; i++) begin
      bus.p1_valid = 1'b1;
      bus.p1_addr = both_p1a[i];
      bus.p1_data = both_p1d[i];
      bus.p2_valid = 1'b1;
      bus.p2_addr = both_p2a[i];
      bus.p2_data = both_p2d[i];
      #1;
      chk($sformatf("rr%0d.p1_ready", i), 32'(bus.p1_ready), 32'(both_grant[i] == 2'b01));
      chk($sformatf("rr%0d.p2_ready", i), 32'(bus.p2_ready), 32'(both_grant[i] == 2'b10));
      tick();
      if (both_grant[i] == 2'b01)
        chk_write($sformatf("rr%0d", i), 1'b1, both_p1a[i], both_p1d[i], 2'b01);
      else
        chk_write($sformatf("rr%0d", i), 1'b1, both_p2a[i], both_p2d[i], 2'b10);
    end
    bus.p1_valid = 1'b0;

    // Clear request beats a simultaneous p2 request.
    bus.clear_req = 1'b1;
    bus.p2_valid = 1'b1;
    bus.p2_addr = 19'd3;
    bus.p2_data = 8'h33;
    #1;
    chk("clr.p2_ready", 32'(bus.p2_ready), 32'd0);
    tick();
    bus.clear_req = 1'b0;
    chk("clr.busy", 32'(bus.clear_busy), 32'd1);
    chk("clr.entry_wren", 32'(bus.wren), 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus.clear_req = (i == 8);
      #1;
      chk($sformatf("clr%0d.p2_ready", i), 32'(bus.p2_ready), 32'd0);
      tick();
      chk_write($sformatf("clr%0d", i), 1'b1, 19'(i), 8'h00, 2'b11);
    end
    bus.clear_req = 1'b0;
    chk("clr.busy_done", 32'(bus.clear_busy), 32'd0);
    #1;
    chk("clr.p2_ready_after", 32'(bus.p2_ready), 32'd1);
    tick();
    bus.p2_valid = 1'b0;
    chk_write("clr.p2", 1'b1, 19'd3, 8'h33, 2'b10);

    // Out-of-range p1 request is consumed and flagged.
    bus.p1_valid = 1'b1;
    bus.p1_addr = 19'd16;
    bus.p1_data = 8'h44;
    #1;
    chk("oor.ready", 32'(bus.p1_ready), 32'd1);
    tick();
    bus.p1_valid = 1'b0;
    chk_write("oor", 1'b0, 19'd3, 8'h33, 2'b00);
    chk("oor.addr_err", 32'(bus.addr_err), 32'd1);
    tick();
    chk("oor.sticky", 32'(bus.addr_err), 32'd1);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    chk("oor.cleared", 32'(bus.addr_err), 32'd0);
    chk("oor.busy", 32'(bus.clear_busy), 32'd1);

    // Reset mid-sweep at address 7, then restart from 0.
    for (int i = 0; i < 8; i++) tick();
    chk("abort.at7", 32'(bus.wraddress), 32'd7);
    reset = 1'b1;
    tick();
    chk_write("abort.rst", 1'b0, 19'd0, 8'h00, 2'b00);
    chk("abort.busy", 32'(bus.clear_busy), 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_write($sformatf("restart%0d", i), 1'b1, 19'(i), 8'h00, 2'b11);
    end
    chk("restart.done", 32'(bus.clear_busy), 32'd0);
    tick();
    chk("restart.idle", 32'(bus.wren), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
